ama_adder_pipe: RTL and testbench

AMA_ADDER_PIPE -- requirements
Module: ama_adder_pipe

---
 rtl/ama_pkg.sv | 26 ++
 rtl/ama_cell.sv | 20 ++
 rtl/ama_adder_pipe.sv | 172 +++++++++++++++++
 tb/tb_ama_adder_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_pkg.sv
// Shared types and the one-bit cell behaviour for the approximate-LSB pipelined adder.
package ama_pkg;

    typedef enum logic [1:0] {
        AMA_EXACT    = 2'd0,
        AMA_INV_COUT = 2'd1,
        AMA_PASS     = 2'd2
    } ama_mode_e;

    // Returns {cout, sum}; any unlisted mode (including 3) behaves as the exact cell.
    function automatic logic [1:0] ama_cell_f(
        input logic       a,
        input logic       b,
        input logic       c,
        input logic [1:0] mode
    );
        logic maj;
        maj = (a & b) | (a & c) | (b & c);
        case (mode)
            AMA_INV_COUT: ama_cell_f = {maj, ~maj};
            AMA_PASS:     ama_cell_f = {a, b};
            default:      ama_cell_f = {maj, a ^ b ^ c};
        endcase
    endfunction

endpackage

// File: rtl/ama_cell.sv
// One-bit adder cell; APPR_EN statically selects whether the mode input is honoured.
module ama_cell
    import ama_pkg::*;
#(
    parameter bit APPR_EN = 1'b0
) (
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_c,
    input  logic [1:0] i_mode,
    output logic       o_s,
    output logic       o_co
);

    logic [1:0] w_mode;

    assign w_mode      = APPR_EN ? i_mode : 2'(AMA_EXACT);
    assign {o_co, o_s} = ama_cell_f(i_a, i_b, i_c, w_mode);

endmodule

// File: rtl/ama_adder_pipe.sv
// Pipelined adder with approximate LSB cells and a global-stall valid/ready handshake.
// Optional AMA_ERRSTAT_EN adds an exact shadow sum and an error counter (ERR_CLR/ERR_CNT).
module ama_adder_pipe
    import ama_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned APPR_BITS = 8,
    parameter int unsigned STAGES    = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [1:0]       MODE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout
`ifdef AMA_ERRSTAT_EN
    ,
    input  logic             ERR_CLR,
    output logic [31:0]      ERR_CNT
`endif
);

    localparam int unsigned SEG = WIDTH / STAGES;

    logic                    w_adv;
    logic [WIDTH-1:0]        w_s;
    logic [WIDTH-1:0]        w_co;
    logic [STAGES-1:0]       w_vld;
    logic [STAGES-1:0]       w_cin;
    logic [STAGES-1:0][1:0]  w_mode;
    logic                    r_out_valid;
    logic                    r_cout;

    // Whole pipeline moves together; the input side is ready exactly when it moves.
    assign w_adv     = OUT_READY | ~r_out_valid;
    assign IN_READY  = w_adv;
    assign OUT_VALID = r_out_valid;
    assign Cout      = r_cout;

    assign w_vld[0]  = IN_VALID;
    assign w_cin[0]  = Cin;
    assign w_mode[0] = MODE;

    // Boundary registers between segment k-1 and segment k.
    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        logic       r_vld;
        logic       r_cin;
        logic [1:0] r_mode;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_vld  <= 1'b0;
                r_cin  <= 1'b0;
                r_mode <= 2'd0;
            end else if (w_adv) begin
                r_vld  <= w_vld[k-1];
                r_cin  <= w_co[k*SEG-1];
                r_mode <= w_mode[k-1];
            end
        end

        assign w_vld[k]  = r_vld;
        assign w_cin[k]  = r_cin;
        assign w_mode[k] = r_mode;
    end

    // Per bit: delay operands to their segment, add, then delay the sum to the output.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int unsigned D = i / SEG;
        localparam int unsigned N = STAGES - D;

        logic         w_a;
        logic         w_b;
        logic         w_c;
        logic [N-1:0] r_s;

        if (D == 0) begin : g_nodly
            assign w_a = A[i];
            assign w_b = B[i];
        end else begin : g_dly
            logic [D-1:0] r_a;
            logic [D-1:0] r_b;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= D'({r_a, A[i]});
                    r_b <= D'({r_b, B[i]});
                end
            end

            assign w_a = r_a[D-1];
            assign w_b = r_b[D-1];
        end

        if (i % SEG == 0) begin : g_cseg
            assign w_c = w_cin[D];
        end else begin : g_cchain
            assign w_c = w_co[i-1];
        end

        ama_cell #(
            .APPR_EN (i < APPR_BITS)
        ) u_cell (
            .i_a    (w_a),
            .i_b    (w_b),
            .i_c    (w_c),
            .i_mode (w_mode[D]),
            .o_s    (w_s[i]),
            .o_co   (w_co[i])
        );

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_s <= '0;
            end else if (w_adv) begin
                r_s <= N'({r_s, w_s[i]});
            end
        end

        assign SUM[i] = r_s[N-1];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_vld[STAGES-1];
            r_cout      <= w_co[WIDTH-1];
        end
    end

`ifdef AMA_ERRSTAT_EN
    localparam int unsigned SW  = WIDTH + 1;
    localparam int unsigned EXW = STAGES * SW;

    logic [SW-1:0]              w_exact;
    logic [STAGES-1:0][SW-1:0]  r_exact;
    logic [31:0]                r_err_cnt;

    assign w_exact = SW'(A) + SW'(B) + SW'(Cin);
    assign ERR_CNT = r_err_cnt;

    // Exact shadow travels in lockstep with the main pipeline.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_exact <= '0;
        end else if (w_adv) begin
            r_exact <= EXW'({r_exact, w_exact});
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || ERR_CLR) begin
            r_err_cnt <= '0;
        end else if (r_out_valid && OUT_READY && ({r_cout, SUM} != r_exact[STAGES-1])
                     && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ama_adder_pipe.sv
// Self-checking bench for ama_adder_pipe (WIDTH=32, APPR_BITS=8, STAGES=2) plus an APPR_BITS=0 twin.
module tb_ama_adder_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned AP = 8;
    localparam int unsigned ST = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IN_VALID;
    logic          OUT_READY;
    logic          Cin;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [1:0]    MODE;
    logic          IN_READY, OUT_VALID, Cout;
    logic [W-1:0]  SUM;
    logic          IN_READY0, OUT_VALID0, Cout0;
    logic [W-1:0]  SUM0;
`ifdef AMA_ERRSTAT_EN
    logic          ERR_CLR;
    logic [31:0]   ERR_CNT, ERR_CNT0;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;

    // Reference pipeline: one slot per stage, holding approximate and exact results.
    logic          m_vld [ST];
    logic [W:0]    m_res [ST];
    logic [W:0]    m_exa [ST];
    logic [31:0]   m_err;

    logic [W-1:0]  v_a    [4] = '{32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_0001, 32'h1234_5678};
    logic [W-1:0]  v_b    [4] = '{32'h0000_0001, 32'h0000_000F, 32'h0000_0001, 32'h0FED_CBA9};
    logic [1:0]    v_m    [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
    logic [W:0]    v_exp  [4] = '{33'h1_0000_0000, 33'h0_0000_010F, 33'h0_0000_00FE, 33'h0_2222_2221};
    logic [31:0]   v_err  [4] = '{32'd0, 32'd1, 32'd2, 32'd2};

    always #5 CLK = ~CLK;

    ama_adder_pipe #(.WIDTH(W), .APPR_BITS(AP), .STAGES(ST)) u_dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .Cin(Cin), .MODE(MODE),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .SUM(SUM), .Cout(Cout)
`ifdef AMA_ERRSTAT_EN
        , .ERR_CLR(ERR_CLR), .ERR_CNT(ERR_CNT)
`endif
    );

    ama_adder_pipe #(.WIDTH(W), .APPR_BITS(0), .STAGES(ST)) u_exact (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY0),
        .A(A), .B(B), .Cin(Cin), .MODE(MODE),
        .OUT_VALID(OUT_VALID0), .OUT_READY(OUT_READY), .SUM(SUM0), .Cout(Cout0)
`ifdef AMA_ERRSTAT_EN
        , .ERR_CLR(ERR_CLR), .ERR_CNT(ERR_CNT0)
`endif
    );

    // Approximate low part bit by bit from the cell rules, exact upper part with plain addition.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic [1:0] m, input int appr);
        logic [W-1:0] lo;
        logic [W:0]   hi;
        logic [1:0]   t;
        logic         cy;
        lo = '0;
        cy = c;
        for (int i = 0; i < appr; i++) begin
            t = 2'(a[i]) + 2'(b[i]) + 2'(cy);
            case (m)
                2'd1:    begin lo[i] = ~t[1]; cy = t[1]; end
                2'd2:    begin lo[i] = b[i];  cy = a[i]; end
                default: begin lo[i] = t[0];  cy = t[1]; end
            endcase
        end
        hi = (W+1)'(a >> appr) + (W+1)'(b >> appr) + (W+1)'(cy);
        return (hi << appr) | (W+1)'(lo);
    endfunction

    // Advance the reference model by one clock using the inputs currently driven, then clock.
    task automatic tick();
        logic adv;
        adv = OUT_READY || !m_vld[ST-1];
        if (RST) begin
            for (int k = 0; k < ST; k++) begin
                m_vld[k] = 1'b0; m_res[k] = '0; m_exa[k] = '0;
            end
            m_err = '0;
        end else begin
`ifdef AMA_ERRSTAT_EN
            if (ERR_CLR) m_err = '0;
            else if (m_vld[ST-1] && OUT_READY && (m_res[ST-1] != m_exa[ST-1]) && (m_err != 32'hFFFF_FFFF))
                m_err = m_err + 32'd1;
`endif
            if (adv) begin
                for (int k = ST - 1; k > 0; k--) begin
                    m_vld[k] = m_vld[k-1]; m_res[k] = m_res[k-1]; m_exa[k] = m_exa[k-1];
                end
                m_vld[0] = IN_VALID;
                m_res[0] = ref_add(A, B, Cin, MODE, AP);
                m_exa[0] = (W+1)'(A) + (W+1)'(B) + (W+1)'(Cin);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1; A = $urandom; B = $urandom; Cin = 1'b1; MODE = 2'd0;
`ifdef AMA_ERRSTAT_EN
        ERR_CLR = 1'b0;
`endif
        tick(); tick();
        RST = 1'b0; IN_VALID = 1'b0;
        #1;
        n_tests++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
        n_tests++; if (SUM !== '0) begin n_fail++; $display("FAIL reset_sum got %h want 0", SUM); end
        n_tests++; if (Cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", Cout); end
        n_tests++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
`ifdef AMA_ERRSTAT_EN
        n_tests++; if (ERR_CNT !== 32'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", ERR_CNT); end
`endif
    endtask

    task automatic test_vectors();
        OUT_READY = 1'b1; Cin = 1'b0;
`ifdef AMA_ERRSTAT_EN
        ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
`endif
        for (int v = 0; v < 4; v++) begin
            IN_VALID = 1'b1; A = v_a[v]; B = v_b[v]; MODE = v_m[v];
            tick();
            IN_VALID = 1'b0; A = $urandom; B = $urandom; MODE = 2'($urandom);
            #1;
            n_tests++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL vec%0d_early_valid got %b want 0", v, OUT_VALID); end
            tick();
            n_tests++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL vec%0d_valid got %b want 1", v, OUT_VALID); end
            n_tests++; if ({Cout, SUM} !== v_exp[v]) begin n_fail++; $display("FAIL vec%0d_result got %h want %h", v, {Cout, SUM}, v_exp[v]); end
            tick();
            n_tests++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL vec%0d_dup got %b want 0", v, OUT_VALID); end
`ifdef AMA_ERRSTAT_EN
            n_tests++; if (ERR_CNT !== v_err[v]) begin n_fail++; $display("FAIL vec%0d_err_cnt got %0d want %0d", v, ERR_CNT, v_err[v]); end
`endif
        end
`ifdef AMA_ERRSTAT_EN
        // Clear coinciding with an erroneous handoff wins.
        IN_VALID = 1'b1; A = v_a[1]; B = v_b[1]; MODE = v_m[1];
        tick();
        IN_VALID = 1'b0;
        tick();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        n_tests++; if (ERR_CNT !== 32'd0) begin n_fail++; $display("FAIL err_clr_priority got %0d want 0", ERR_CNT); end
`endif
    endtask

    task automatic test_stall();
        logic [W:0] q[$];
        logic [W:0] held;
        logic [W:0] want;
        logic [W-1:0] ba [4];
        logic [W-1:0] bb [4];
        int idx, got;
        for (int i = 0; i < 4; i++) begin ba[i] = $urandom; bb[i] = $urandom; end
        idx = 0; got = 0; held = '0;
        Cin = 1'b1; MODE = 2'd0;
        for (int t = 0; t < 40 && !(got == 4 && idx == 4); t++) begin
            OUT_READY = !(t >= 2 && t <= 4);
            IN_VALID  = (idx < 4);
            A = (idx < 4) ? ba[idx] : '0;
            B = (idx < 4) ? bb[idx] : '0;
            #1;
            if (t == 2) held = {Cout, SUM};
            if (t >= 2 && t <= 4) begin
                n_tests++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready t=%0d got %b want 0", t, IN_READY); end
                n_tests++; if ({OUT_VALID, Cout, SUM} !== {1'b1, held}) begin n_fail++; $display("FAIL stall_hold t=%0d got %b/%h want 1/%h", t, OUT_VALID, {Cout, SUM}, held); end
            end
            if (OUT_VALID && OUT_READY) begin
                want = (q.size() > 0) ? q.pop_front() : 'x;
                got++;
                n_tests++; if ({Cout, SUM} !== want) begin n_fail++; $display("FAIL stall_order beat%0d got %h want %h", got, {Cout, SUM}, want); end
            end
            if (IN_VALID && IN_READY) begin
                q.push_back(ref_add(A, B, Cin, MODE, AP));
                idx++;
            end
            tick();
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        n_tests++; if (got !== 4 || idx !== 4) begin n_fail++; $display("FAIL stall_count got %0d out/%0d in want 4/4", got, idx); end
    endtask

    task automatic test_reset_midflight();
        OUT_READY = 1'b1; MODE = 2'd0; Cin = 1'b0;
        for (int i = 0; i < 2; i++) begin
            IN_VALID = 1'b1; A = $urandom; B = $urandom;
            tick();
        end
        IN_VALID = 1'b0; RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        n_tests++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", OUT_VALID); end
        n_tests++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", IN_READY); end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++; if ((OUT_VALID | OUT_VALID0) !== 1'b0) begin n_fail++; $display("FAIL midrst_stale c=%0d got %b/%b want 0/0", c, OUT_VALID, OUT_VALID0); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            IN_VALID  = ($urandom % 4) != 0;
            OUT_READY = ($urandom % 4) != 0;
            A    = (($urandom % 8) == 0) ? '1 : W'($urandom);
            B    = (($urandom % 8) == 0) ? '1 : W'($urandom);
            Cin  = 1'($urandom);
            MODE = 2'($urandom);
`ifdef AMA_ERRSTAT_EN
            ERR_CLR = ($urandom % 50) == 0;
`endif
            #1;
            n_tests++; if (IN_READY !== (OUT_READY || !m_vld[ST-1])) begin n_fail++; $display("FAIL rnd_in_ready c=%0d got %b want %b", c, IN_READY, OUT_READY || !m_vld[ST-1]); end
            n_tests++; if (OUT_VALID !== m_vld[ST-1]) begin n_fail++; $display("FAIL rnd_out_valid c=%0d got %b want %b", c, OUT_VALID, m_vld[ST-1]); end
            if (m_vld[ST-1]) begin
                n_tests++; if ({Cout, SUM} !== m_res[ST-1]) begin n_fail++; $display("FAIL rnd_approx c=%0d got %h want %h", c, {Cout, SUM}, m_res[ST-1]); end
                n_tests++; if ({Cout0, SUM0} !== m_exa[ST-1]) begin n_fail++; $display("FAIL rnd_exact c=%0d got %h want %h", c, {Cout0, SUM0}, m_exa[ST-1]); end
            end
`ifdef AMA_ERRSTAT_EN
            n_tests++; if (ERR_CNT !== m_err) begin n_fail++; $display("FAIL rnd_err_cnt c=%0d got %0d want %0d", c, ERR_CNT, m_err); end
            n_tests++; if (ERR_CNT0 !== 32'd0) begin n_fail++; $display("FAIL rnd_err_cnt_exact c=%0d got %0d want 0", c, ERR_CNT0); end
`endif
            tick();
        end
`ifdef AMA_ERRSTAT_EN
        ERR_CLR = 1'b0;
`endif
        IN_VALID = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < ST; k++) begin m_vld[k] = 1'b0; m_res[k] = '0; m_exa[k] = '0; end
        m_err = '0;
        test_reset();
        test_vectors();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
